// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotating active-low row strobe, synchronised column sampling,
// frame-level debounce, and a nibble-shift entry register of accepted keys.
module keypad_scan #(
   parameter int unsigned SCAN_CNT   = 100000,
   parameter int unsigned DEB_FRAMES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  col_in,
   input  logic        clear,
   output logic [3:0]  row_out,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [31:0] key_data
);

   localparam int unsigned CW = $clog2(SCAN_CNT);
   localparam int unsigned DW = $clog2(DEB_FRAMES + 1);
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CNT - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_FRAMES);

   typedef enum logic [1:0] {
      StReleased,
      StPressDeb,
      StPressed,
      StReleaseDeb
   } state_e;

   logic [3:0]    col_meta;
   logic [3:0]    col_sync;
   logic [CW-1:0] scan_cnt;
   logic [1:0]    row_idx;
   logic [11:0]   frame_q;
   logic [15:0]   frame_bits;
   logic          sample;
   logic          frame_end;
   logic          cls_none;
   logic          cls_single;
   logic [3:0]    key_idx;
   logic [3:0]    cand_code;
   state_e        state;
   logic [DW-1:0] deb_cnt;
   logic [3:0]    cand;

   function automatic logic [3:0] key_map(input logic [3:0] idx);
      logic [3:0] code;
      unique case (idx)
         4'd0:    code = 4'h1;
         4'd1:    code = 4'h2;
         4'd2:    code = 4'h3;
         4'd3:    code = 4'hA;
         4'd4:    code = 4'h4;
         4'd5:    code = 4'h5;
         4'd6:    code = 4'h6;
         4'd7:    code = 4'hB;
         4'd8:    code = 4'h7;
         4'd9:    code = 4'h8;
         4'd10:   code = 4'h9;
         4'd11:   code = 4'hC;
         4'd12:   code = 4'hE;
         4'd13:   code = 4'h0;
         4'd14:   code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   // Columns are asynchronous to clk; idle (pulled-up) value is all ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_meta <= 4'hF;
         col_sync <= 4'hF;
      end else begin
         col_meta <= col_in;
         col_sync <= col_meta;
      end
   end

   assign sample    = (scan_cnt == SCAN_LAST);
   assign frame_end = sample && (row_idx == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt <= '0;
         row_idx  <= 2'd0;
         row_out  <= 4'b1110;
         frame_q  <= '0;
      end else if (sample) begin
         scan_cnt <= '0;
         row_idx  <= row_idx + 2'd1;
         row_out  <= ~(4'b0001 << (row_idx + 2'd1));
         case (row_idx)
            2'd0:    frame_q[3:0]  <= ~col_sync;
            2'd1:    frame_q[7:4]  <= ~col_sync;
            2'd2:    frame_q[11:8] <= ~col_sync;
            default: ;
         endcase
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Row 3 is classified straight from the synchroniser on its own sample cycle.
   assign frame_bits = {~col_sync, frame_q};
   assign cls_none   = (frame_bits == 16'd0);
   assign cls_single = !cls_none && ((frame_bits & (frame_bits - 16'd1)) == 16'd0);
   assign cand_code  = key_map(cand);

   always_comb begin
      key_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (frame_bits[i]) key_idx = 4'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= StReleased;
         deb_cnt   <= '0;
         cand      <= 4'd0;
         key_valid <= 1'b0;
         key_code  <= 4'h0;
         key_data  <= 32'h0;
      end else begin
         key_valid <= 1'b0;
         if (clear) key_data <= 32'h0;
         if (frame_end) begin
            unique case (state)
               StReleased: begin
                  if (cls_single) begin
                     cand    <= key_idx;
                     deb_cnt <= DW'(1);
                     state   <= StPressDeb;
                  end
               end
               StPressDeb: begin
                  if (cls_single && (key_idx == cand)) begin
                     deb_cnt <= deb_cnt + 1'b1;
                     if ((deb_cnt + 1'b1) == DEB_LAST) begin
                        key_valid <= 1'b1;
                        key_code  <= cand_code;
                        key_data  <= clear ? {28'h0, cand_code} : {key_data[27:0], cand_code};
                        state     <= StPressed;
                     end
                  end else begin
                     state <= StReleased;
                  end
               end
               StPressed: begin
                  if (cls_none) begin
                     deb_cnt <= DW'(1);
                     state   <= StReleaseDeb;
                  end
               end
               StReleaseDeb: begin
                  if (cls_none) begin
                     deb_cnt <= deb_cnt + 1'b1;
                     if ((deb_cnt + 1'b1) == DEB_LAST) state <= StReleased;
                  end else begin
                     state <= StPressed;
                  end
               end
               default: state <= StReleased;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad model drives the columns, a frame-level reference model
// predicts accepted keys into a scoreboard, and a monitor checks every key_valid pulse.
module tb_keypad_scan;

   localparam int SCAN = 4;
   localparam int DEB  = 2;
   localparam int FRAME = 4 * SCAN;
   localparam int M_REL = 0, M_PDEB = 1, M_PRS = 2, M_RDEB = 3;

   typedef struct {
      logic [3:0]  code;
      logic [31:0] data;
      int          stamp;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [31:0] key_data;
   logic [15:0] keys = 16'h0;

   int errors = 0;
   int checks = 0;
   int tcnt = 0;
   int pulses = 0;
   exp_t sb[$];

   string kmap = "123A456B789CE0FD";
   int m_state, m_cnt, m_cand;
   logic [3:0]  m_code;
   logic [31:0] m_data;

   always #5 clk = ~clk;

   keypad_scan #(
      .SCAN_CNT  (SCAN),
      .DEB_FRAMES(DEB)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .col_in   (col_in),
      .clear    (clear),
      .row_out  (row_out),
      .key_valid(key_valid),
      .key_code (key_code),
      .key_data (key_data)
   );

   // Physical keypad: a held key shorts its row line onto its column line.
   always_comb begin
      col_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!row_out[r] && keys[4*r+c]) col_in[c] = 1'b0;
         end
      end
   end

   always @(posedge clk) tcnt <= reset ? 0 : tcnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, tcnt);
      end
   endtask

   function automatic logic [3:0] code_of(input int k);
      byte c;
      c = kmap[k];
      if (c >= "A") return 4'(c - "A" + 10);
      return 4'(c - "0");
   endfunction

   function automatic int idx_of(input logic [3:0] code);
      for (int i = 0; i < 16; i++) begin
         if (code_of(i) == code) return i;
      end
      return 0;
   endfunction

   function automatic logic [15:0] kb(input int k);
      return 16'h1 << k;
   endfunction

   // One frame of the debounce rules; clear anywhere in the frame precedes its accept.
   task automatic model_frame(input logic [15:0] s, input bit clr, input int stamp);
      int n = $countones(s);
      int k = -1;
      for (int i = 0; i < 16; i++) if (s[i]) k = i;
      if (clr) m_data = 32'h0;
      case (m_state)
         M_REL: if (n == 1) begin
            m_cand = k; m_cnt = 1; m_state = M_PDEB;
         end
         M_PDEB: if (n == 1 && k == m_cand) begin
            m_cnt++;
            if (m_cnt == DEB) begin
               m_code = code_of(m_cand);
               m_data = {m_data[27:0], m_code};
               sb.push_back('{m_code, m_data, stamp});
               m_state = M_PRS;
            end
         end else m_state = M_REL;
         M_PRS: if (n == 0) begin
            m_cnt = 1; m_state = M_RDEB;
         end
         default: if (n == 0) begin
            m_cnt++;
            if (m_cnt == DEB) m_state = M_REL;
         end else m_state = M_PRS;
      endcase
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && key_valid) begin
         pulses++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key_valid: got code %h data %h at cycle %0d, expected none",
                     key_code, key_data, tcnt);
         end else begin
            e = sb.pop_front();
            check("key_code", {28'h0, key_code}, {28'h0, e.code});
            check("key_data_at_accept", key_data, e.data);
            check("accept_cycle", tcnt, e.stamp);
         end
      end
   end

   // Called at a frame-start negedge; leaves on the next frame-start negedge.
   task automatic run_frame(input logic [15:0] s, input int clr_pos);
      int base = tcnt;
      logic [3:0] er;
      check("key_data_hold", key_data, m_data);
      check("key_code_hold", {28'h0, key_code}, {28'h0, m_code});
      keys = s;
      model_frame(s, clr_pos >= 0, base + FRAME);
      for (int p = 0; p < FRAME; p++) begin
         er = ~(4'b0001 << (p / SCAN));
         check("row_out", {28'h0, row_out}, {28'h0, er});
         clear = (p == clr_pos);
         @(negedge clk);
      end
      clear = 1'b0;
   endtask

   task automatic hold(input logic [15:0] s, input int n, input int clr_pos);
      for (int i = 0; i < n; i++) run_frame(s, (i == 0) ? clr_pos : -1);
   endtask

   task automatic press(input logic [3:0] code, input int n_hold, input int n_rel);
      hold(kb(idx_of(code)), n_hold, -1);
      hold(16'h0, n_rel, -1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_row_out", {28'h0, row_out}, 32'he);
      check("reset_key_valid", {31'h0, key_valid}, 32'h0);
      check("reset_key_code", {28'h0, key_code}, 32'h0);
      check("reset_key_data", key_data, 32'h0);
      check("pending_before_reset", sb.size(), 0);
      sb.delete();
      m_state = M_REL; m_cnt = 0; m_cand = 0; m_code = 4'h0; m_data = 32'h0;
      reset = 1'b0;
   endtask

   initial begin
      int p0;
      logic [15:0] s;
      int r, k, k2, n, cp;

      do_reset();
      hold(16'h0, 2, -1);

      // Single key: row1/col2 is '6'.
      hold(kb(6), 6, -1);
      hold(16'h0, 3, -1);
      check("single_code", {28'h0, key_code}, 32'h6);
      check("single_data", key_data, 32'h6);

      // Sequence after a clear.
      hold(16'h0, 1, 5);
      press(4'h1, 4, 4);
      press(4'h2, 4, 4);
      press(4'h3, 4, 4);
      press(4'hA, 4, 4);
      check("sequence_data", key_data, 32'h0000123A);

      // Rejections: short press, two keys, release glitch inside a long hold.
      p0 = pulses;
      hold(kb(1), 1, -1);
      hold(16'h0, 3, -1);
      hold(kb(0) | kb(1), 6, -1);
      hold(16'h0, 3, -1);
      hold(kb(9), 4, -1);
      hold(16'h0, 1, -1);
      hold(kb(9), 4, -1);
      hold(16'h0, 3, -1);
      check("rejection_pulses", pulses - p0, 1);

      // Wrap, clear, and clear coinciding with an accept.
      hold(16'h0, 1, 7);
      for (int d = 1; d <= 9; d++) press(4'(d), 2, 2);
      check("wrap_data", key_data, 32'h23456789);
      hold(16'h0, 1, 5);
      check("clear_data", key_data, 32'h0);
      hold(kb(idx_of(4'h5)), 1, -1);
      hold(kb(idx_of(4'h5)), 1, FRAME - 1);
      hold(16'h0, 3, -1);
      check("clear_accept_data", key_data, 32'h5);

      // Reset with key 0 still held: accepted again from a clean register.
      hold(kb(idx_of(4'h0)), 3, -1);
      do_reset();
      p0 = pulses;
      hold(kb(idx_of(4'h0)), 3, -1);
      check("reaccept_pulses", pulses - p0, 1);
      check("reaccept_data", key_data, 32'h0);
      hold(16'h0, 3, -1);

      // Random keying against the reference model.
      for (int seg = 0; seg < 60; seg++) begin
         r = int'($urandom_range(0, 9));
         k = int'($urandom_range(0, 15));
         if (r < 7) begin
            s = kb(k);
            n = int'($urandom_range(1, 5));
         end else if (r < 9) begin
            k2 = (k + int'($urandom_range(1, 15))) % 16;
            s = kb(k) | kb(k2);
            n = int'($urandom_range(1, 3));
         end else begin
            s = 16'h0;
            n = int'($urandom_range(1, 2));
         end
         cp = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, FRAME - 1)) : -1;
         hold(s, n, cp);
         hold(16'h0, int'($urandom_range(0, 4)), -1);
      end
      hold(16'h0, 4, -1);

      @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

4x4 matrix keypad scanner: the input-side counterpart of the seven-segment tube driver. It drives keypad rows with a rotating active-low strobe and samples the columns. Each sample is debounced, and every accepted key becomes a hex nibble that is shifted into a 32-bit entry register. The CPU's MMIO input path reads that register; the tube driver can echo it back to the user.

## Interface
Parameters:
- SCAN_CNT, 100000: clk cycles each row stays driven (1 ms at 100 MHz); must be >= 2.
- DEB_FRAMES, 4: consecutive identical full-scan frames needed to accept a press or a release; must be >= 2.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- col_in  input  4  keypad columns, active-low, externally pulled up, asynchronous.
- clear  input  1  single-cycle pulse; zeroes key_data.
- row_out  output  4  row strobe, active-low one-hot.
- key_valid  output  1  one-cycle pulse per accepted key.
- key_code  output  4  hex value of the last accepted key.
- key_data  output  32  nibble-shift entry register.

## Operation
- **Column sync:** col_in passes through a 2-flop synchronizer. A column is "pressed" when its synced bit is 0.
- **Row scan:**
  - Counter runs 0..SCAN_CNT-1.
  - row index r runs 0..3; row_out = ~(1<<r).
  - When the counter reaches SCAN_CNT-1 (the sample cycle), the synced columns for row r are latched and r advances, wrapping 3->0.
- **Frame:** one frame is four rows. At row 3's sample cycle the frame is classified as:
  - NONE: no pressed bit in all 16.
  - SINGLE(k): exactly one bit, k = 4*r + c.
  - MULTI: more than one bit. MULTI is never accepted.
- **Key map (row-major, col 0..3):**
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D (the "*" key is E, "#" is F)
- **FSM (evaluated once per frame end):**
  - RELEASED:
    - SINGLE(k): cand=k, cnt=1, go to PRESS_DEB.
    - Otherwise stay.
  - PRESS_DEB:
    - SINGLE(cand): cnt+1. When cnt reaches DEB_FRAMES, accept and go to PRESSED.
    - Any other frame: go to RELEASED.
  - PRESSED:
    - NONE: cnt=1, go to RELEASE_DEB.
    - Anything else: stay. There is no auto-repeat.
  - RELEASE_DEB:
    - NONE: cnt+1. When cnt reaches DEB_FRAMES, go to RELEASED.
    - Anything else: go to PRESSED.
- **Accept action:**
  - key_valid=1 for one cycle.
  - key_code = map(cand).
  - key_data = {key_data[27:0], map(cand)}; the oldest nibble drops off and there is no saturation.
- **clear:** key_data <= 0.
  - If clear coincides with an accept, key_data = {28'h0, code}. key_valid and key_code update as normal.
- **Reset:** any state returns to RELEASED. A key still held after reset is debounced and accepted again.

## Timing
- **Reset values:**
  - row_out = 4'b1110, r = 0, scan counter = 0.
  - Synchronizer flops = 4'b1111.
  - State RELEASED, cnt = 0, cand = 0.
  - key_valid = 0, key_code = 4'h0, key_data = 32'h0.
- Column latency is 2 cycles through the synchronizer. The sample is taken at the end of the row dwell, so there are SCAN_CNT-2 cycles of settle after the synchronizer.
- row_out changes on the clock edge after the sample cycle.
- key_valid, key_code and key_data all update on the edge ending the frame-final sample cycle.
  - key_valid is high for exactly one cycle.
  - key_code and key_data hold their values until the next accept, clear or reset.
- **Accept latency:** a press stable from the start of a frame is accepted at the end of frame DEB_FRAMES.
  - Worst case is (DEB_FRAMES+1)*4*SCAN_CNT + 2 cycles.
- **Minimum key spacing:** DEB_FRAMES frames held, plus DEB_FRAMES frames released.
- The scan counter and row index keep running through every FSM state and through clear; only reset disturbs them.

## Test plan
Bench parameters: SCAN_CNT=4, DEB_FRAMES=2, so one frame is 16 cycles.

1. **Reset:** hold reset 3 cycles, col_in=4'hF -> row_out=1110, key_valid=0, key_code=0, key_data=0. row_out then rotates 1110->1101->1011->0111 every 4 cycles.
2. **Single key:** hold the row1/col2 key (drive col_in[2]=0 while row_out=1101) for 6 frames, then release -> exactly one key_valid pulse, key_code=6, key_data=32'h00000006.
3. **Sequence:** press/release keys 1, 2, 3, A (each held 4 frames, released 4 frames) -> four pulses, key_data=32'h0000123A.
4. **Rejection:**
   - A press lasting 1 frame -> no key_valid.
   - Row0/col0 and row0/col1 held together for 6 frames -> no key_valid.
   - A 1-frame release gap inside a long hold -> still only one pulse.
5. **Wrap and clear:** enter 1..9 -> key_data=32'h23456789. Then a clear pulse -> key_data=0. Then clear coinciding with the accept of 5 -> key_data=32'h00000005.
6. **Reset mid-hold:** key 0 accepted (state PRESSED), assert reset with the key still held -> outputs return to reset values, then key 0 is accepted again within 3 frames and key_data=0.
